// File: rtl/perf_mon_pkg.sv
// perf_mon_pkg
//   Shared constants for the performance monitor: default counter width,
//   readout selector encodings and readout FSM state encoding.
//   Optional macro used by the design: PERF_MON_OVF_EN (wrapping counters
//   with sticky overflow flags instead of saturating counters).
package perf_mon_pkg;

    localparam int CNT_W_DEFAULT = 32;

    typedef logic [1:0] rd_sel_t;

    localparam rd_sel_t SEL_CYCLES  = 2'd0;
    localparam rd_sel_t SEL_INSTR   = 2'd1;
    localparam rd_sel_t SEL_STALLS  = 2'd2;
    localparam rd_sel_t SEL_FLUSHES = 2'd3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RESP = 1'b1;

endpackage

// File: rtl/perf_event_counter.sv
// perf_event_counter
//   One live event counter of the performance monitor.
//   Macro PERF_MON_OVF_EN: when defined the counter wraps modulo 2^W and
//   raises a sticky ovf flag on the wrap edge; otherwise it saturates.
// Ports:
//   clk    in   clock, posedge
//   rst    in   synchronous active-high reset
//   inc    in   count one event this cycle
//   clear  in   zero the counter (wins over inc)
//   value  out  current count
//   ovf    out  sticky wrap flag (only with PERF_MON_OVF_EN)
module perf_event_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clear,
`ifdef PERF_MON_OVF_EN
    output logic         ovf,
`endif
    output logic [W-1:0] value
);

    localparam logic [W-1:0] ONE = W'(1);

`ifdef PERF_MON_OVF_EN
    // Wrapping counter; the flag is set when an increment leaves the
    // all-ones value and is only cleared by rst or clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
            ovf   <= 1'b0;
        end else if (clear) begin
            value <= '0;
            ovf   <= 1'b0;
        end else if (inc) begin
            value <= value + ONE;
            if (&value)
                ovf <= 1'b1;
        end
    end
`else
    // Saturating counter: it sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc && !(&value)) begin
            value <= value + ONE;
        end
    end
`endif

endmodule

// File: rtl/perf_monitor.sv
// perf_monitor
//   In-processor performance monitor. Counts cycles, retired instructions,
//   stall cycles and flushes, emits a periodic report pulse, snapshots the
//   live counters into shadow registers and serves shadow values through a
//   request/valid/ack readout port.
//   Macro PERF_MON_OVF_EN: wrapping counters plus the ovf[3:0] output
//   (bit order cycles, instr, stalls, flushes); default is saturation.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   en                   counting enable for all four counters
//   retire/stall/flush   core event strobes
//   clear                zero the live counters
//   snap_req             copy live counters into the shadows
//   report_tick          one-cycle pulse every REPORT_INTERVAL cycles
//   rd_req, rd_sel       read request and shadow selector
//   rd_ready             high while the readout port is idle
//   rd_valid, rd_data    response, held until rd_ack
//   rd_ack               response consumed
//   ovf                  sticky overflow flags (PERF_MON_OVF_EN only)
module perf_monitor
    import perf_mon_pkg::*;
#(
    parameter int CNT_W           = CNT_W_DEFAULT,
    parameter int REPORT_INTERVAL = 500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             retire,
    input  logic             stall,
    input  logic             flush,
    input  logic             clear,
    input  logic             snap_req,
    output logic             report_tick,
    input  logic             rd_req,
    input  logic [1:0]       rd_sel,
    output logic             rd_ready,
    output logic             rd_valid,
    output logic [CNT_W-1:0] rd_data,
`ifdef PERF_MON_OVF_EN
    output logic [3:0]       ovf,
`endif
    input  logic             rd_ack
);

    localparam int IW = (REPORT_INTERVAL > 2) ? $clog2(REPORT_INTERVAL) : 1;
    localparam logic [IW-1:0] LAST = IW'(REPORT_INTERVAL - 1);
    localparam logic [IW-1:0] ONE  = IW'(1);

    logic [3:0]       inc_vec;
    logic [CNT_W-1:0] live   [4];
    logic [CNT_W-1:0] shadow [4];
    logic [IW-1:0]    interval;
    logic             report_edge;
    logic             snap;
    logic [0:0]       state;
    logic [CNT_W-1:0] sel_val;

    // Index 0..3 follows the rd_sel encoding: cycles, instr, stalls, flushes.
    assign inc_vec = {en & flush, en & stall, en & retire, en};

    for (genvar i = 0; i < 4; i++) begin : g_cnt
        perf_event_counter #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc_vec[i]),
            .clear (clear),
`ifdef PERF_MON_OVF_EN
            .ovf   (ovf[i]),
`endif
            .value (live[i])
        );
    end

    assign report_edge = (interval == LAST);
    assign snap        = snap_req | report_edge;

    // Free-running interval counter, independent of en and clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            interval    <= '0;
            report_tick <= 1'b0;
        end else begin
            interval    <= report_edge ? '0 : interval + ONE;
            report_tick <= report_edge;
        end
    end

    // Shadows take the live values as they stand before this edge, so a
    // snapshot coinciding with clear still captures the pre-clear counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++)
                shadow[i] <= '0;
        end else if (snap) begin
            for (int i = 0; i < 4; i++)
                shadow[i] <= live[i];
        end
    end

    always_comb begin
        sel_val = shadow[0];
        case (rd_sel)
            SEL_CYCLES:  sel_val = shadow[0];
            SEL_INSTR:   sel_val = shadow[1];
            SEL_STALLS:  sel_val = shadow[2];
            SEL_FLUSHES: sel_val = shadow[3];
            default:     sel_val = shadow[0];
        endcase
    end

    // Readout FSM: rd_data is only written on acceptance in IDLE, which
    // keeps it frozen for the whole response regardless of new snapshots.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_req) begin
                        rd_data  <= sel_val;
                        rd_valid <= 1'b1;
                        state    <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rd_ack) begin
                        rd_valid <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                default: begin
                    rd_valid <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd_ready = (state == ST_IDLE);

endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor
//   Self-checking bench for perf_monitor. Two instances share the stimulus:
//   dut0 (CNT_W=32, REPORT_INTERVAL=8) and dut1 (CNT_W=4, REPORT_INTERVAL=500).
//   Both are compared every cycle against an arithmetic reference model; a
//   vector table and hand-written sequences add fixed expected values.
//   Honours PERF_MON_OVF_EN for the wrap/ovf variant.
module tb_perf_monitor;

    localparam int W0 = 32;
    localparam int R0 = 8;
    localparam int W1 = 4;
    localparam int R1 = 500;

    logic clk = 1'b0;
    logic rst, en, retire, stall, flush, clear, snap_req, rd_req, rd_ack;
    logic [1:0] rd_sel;

    logic          tick0, ready0, valid0;
    logic [W0-1:0] data0;
    logic          tick1, ready1, valid1;
    logic [W1-1:0] data1;
`ifdef PERF_MON_OVF_EN
    logic [3:0]    ovf0, ovf1;
`endif

    always #10 clk = ~clk;

    perf_monitor #(.CNT_W(W0), .REPORT_INTERVAL(R0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .retire(retire), .stall(stall),
        .flush(flush), .clear(clear), .snap_req(snap_req),
        .report_tick(tick0), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_ready(ready0), .rd_valid(valid0), .rd_data(data0),
`ifdef PERF_MON_OVF_EN
        .ovf(ovf0),
`endif
        .rd_ack(rd_ack)
    );

    perf_monitor #(.CNT_W(W1), .REPORT_INTERVAL(R1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .retire(retire), .stall(stall),
        .flush(flush), .clear(clear), .snap_req(snap_req),
        .report_tick(tick1), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_ready(ready1), .rd_valid(valid1), .rd_data(data1),
`ifdef PERF_MON_OVF_EN
        .ovf(ovf1),
`endif
        .rd_ack(rd_ack)
    );

    typedef struct {
        bit       rst, en, retire, stall, flush, clear, snap, req;
        bit [1:0] sel;
        bit       ack;
        bit       chk;
        bit       exp_valid, exp_ready;
        longint   exp_data;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state, index = instance.
    longint m_live   [2][4];
    longint m_shadow [2][4];
    longint m_int    [2];
    bit     m_tick   [2];
    bit     m_busy   [2];
    longint m_data   [2];
    bit [3:0] m_ovf  [2];

    function automatic vec_t mk(bit r, bit e, bit ret, bit st, bit fl, bit cl,
                                bit sn, bit rq, bit [1:0] sl, bit ak,
                                bit chk, bit ev, bit er, longint ed);
        vec_t v;
        v.rst = r; v.en = e; v.retire = ret; v.stall = st; v.flush = fl;
        v.clear = cl; v.snap = sn; v.req = rq; v.sel = sl; v.ack = ak;
        v.chk = chk; v.exp_valid = ev; v.exp_ready = er; v.exp_data = ed;
        return v;
    endfunction

    function automatic vec_t idle_v(bit e, bit ret);
        return mk(0, e, ret, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    endfunction

    task automatic cmpv(input string name, input logic [63:0] act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Next model state from the rules: reads and snapshots see the values
    // present before the edge; clear beats increment.
    task automatic model_step(input vec_t v);
        for (int k = 0; k < 2; k++) begin
            int     w   = (k == 0) ? W0 : W1;
            longint r   = (k == 0) ? R0 : R1;
            longint mx  = (longint'(1) << w) - 1;
            bit     rep;
            bit     incs [4];
            if (v.rst) begin
                for (int c = 0; c < 4; c++) begin
                    m_live[k][c] = 0;
                    m_shadow[k][c] = 0;
                end
                m_int[k] = 0; m_tick[k] = 0; m_busy[k] = 0; m_data[k] = 0;
                m_ovf[k] = 4'b0;
            end else begin
                rep = (m_int[k] == r - 1);
                if (!m_busy[k] && v.req) begin
                    m_data[k] = m_shadow[k][v.sel];
                    m_busy[k] = 1;
                end else if (m_busy[k] && v.ack) begin
                    m_busy[k] = 0;
                end
                if (v.snap || rep)
                    for (int c = 0; c < 4; c++) m_shadow[k][c] = m_live[k][c];
                m_tick[k] = rep;
                m_int[k]  = rep ? 0 : m_int[k] + 1;
                incs[0] = v.en; incs[1] = v.en & v.retire;
                incs[2] = v.en & v.stall; incs[3] = v.en & v.flush;
                for (int c = 0; c < 4; c++) begin
                    if (v.clear) begin
                        m_live[k][c] = 0;
                        m_ovf[k][c] = 1'b0;
                    end else if (incs[c]) begin
`ifdef PERF_MON_OVF_EN
                        if (m_live[k][c] == mx) begin
                            m_live[k][c] = 0;
                            m_ovf[k][c] = 1'b1;
                        end else m_live[k][c] = m_live[k][c] + 1;
`else
                        if (m_live[k][c] < mx) m_live[k][c] = m_live[k][c] + 1;
`endif
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst = v.rst; en = v.en; retire = v.retire; stall = v.stall;
        flush = v.flush; clear = v.clear; snap_req = v.snap; rd_req = v.req;
        rd_sel = v.sel; rd_ack = v.ack;
        model_step(v);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        cmpv("tick0",  64'(tick0),  longint'(m_tick[0]));
        cmpv("ready0", 64'(ready0), longint'(!m_busy[0]));
        cmpv("valid0", 64'(valid0), longint'(m_busy[0]));
        cmpv("data0",  64'(data0),  m_data[0]);
        cmpv("tick1",  64'(tick1),  longint'(m_tick[1]));
        cmpv("ready1", 64'(ready1), longint'(!m_busy[1]));
        cmpv("valid1", 64'(valid1), longint'(m_busy[1]));
        cmpv("data1",  64'(data1),  m_data[1]);
`ifdef PERF_MON_OVF_EN
        cmpv("ovf0", 64'(ovf0), longint'(m_ovf[0]));
        cmpv("ovf1", 64'(ovf1), longint'(m_ovf[1]));
`endif
    endtask

    task automatic step(input vec_t v);
        applyStimulus(v);
        checkOutput();
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;

        rst = 1; en = 0; retire = 0; stall = 0; flush = 0; clear = 0;
        snap_req = 0; rd_req = 0; rd_sel = 0; rd_ack = 0;
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 4; c++) begin m_live[k][c] = 0; m_shadow[k][c] = 0; end
            m_int[k] = 0; m_tick[k] = 0; m_busy[k] = 0; m_data[k] = 0; m_ovf[k] = 0;
        end

        // Counting table (dut0): 10 enabled edges, retire on 7, snap, two reads.
        tbl.push_back(mk(1,0,0,0,0,0,0,0,2'd0,0, 1,0,1,0));
        for (int i = 0; i < 10; i++)
            tbl.push_back(mk(0,1,(i < 7),0,0,0,0,0,2'd0,0, 1,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,1,0,2'd0,0, 1,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,2'd0,0, 1,1,0,10));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,2'd0,0, 1,1,0,10));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,2'd0,1, 1,0,1,10));
        tbl.push_back(mk(0,0,0,0,0,0,0,1,2'd1,0, 1,1,0,7));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,2'd1,1, 1,0,1,7));
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i]);
            if (tbl[i].chk) begin
                cmpv("tbl_valid", 64'(valid0), longint'(tbl[i].exp_valid));
                cmpv("tbl_ready", 64'(ready0), longint'(tbl[i].exp_ready));
                cmpv("tbl_data",  64'(data0),  tbl[i].exp_data);
            end
        end

        // Report tick: pulse only after edges 8 and 16; then width check.
        step(mk(1,0,0,0,0,0,0,0,2'd0,0, 0,0,0,0));
        for (int e = 1; e <= 20; e++) begin
            step(idle_v(1, 0));
            cmpv("tick_at_edge", 64'(tick0), longint'((e == 8) || (e == 16)));
        end
        step(mk(0,0,0,0,0,0,1,0,2'd0,0, 0,0,0,0));
        step(mk(0,0,0,0,0,0,0,1,2'd0,0, 0,0,0,0));
        cmpv("cycles_w32", 64'(data0), 20);
`ifdef PERF_MON_OVF_EN
        cmpv("cycles_w4_wrap", 64'(data1), 4);
        cmpv("ovf_w4_set", 64'(ovf1[0]), 1);
        step(mk(0,0,0,0,0,0,0,0,2'd0,1, 0,0,0,0));
        step(idle_v(0, 0));
        cmpv("ovf_w4_sticky", 64'(ovf1[0]), 1);
        step(mk(0,0,0,0,0,1,0,0,2'd0,0, 0,0,0,0));
        cmpv("ovf_w4_cleared", 64'(ovf1[0]), 0);
`else
        cmpv("cycles_w4_sat", 64'(data1), 15);
        step(mk(0,0,0,0,0,0,0,0,2'd0,1, 0,0,0,0));
`endif

        // Clear priority: instr=5, then clear+retire+snap on one edge.
        step(mk(1,0,0,0,0,0,0,0,2'd0,0, 0,0,0,0));
        for (int i = 0; i < 5; i++) step(idle_v(1, 1));
        step(mk(0,1,1,0,0,1,1,0,2'd0,0, 0,0,0,0));
        step(mk(0,0,0,0,0,0,0,1,2'd1,0, 0,0,0,0));
        cmpv("clr_shadow_instr", 64'(data0), 5);
        step(mk(0,0,0,0,0,0,0,0,2'd1,1, 0,0,0,0));
        step(idle_v(1, 1));
        step(mk(0,0,0,0,0,0,1,0,2'd0,0, 0,0,0,0));
        step(mk(0,0,0,0,0,0,0,1,2'd1,0, 0,0,0,0));
        cmpv("clr_live_instr", 64'(data0), 1);

        // Response stability: snapshots and rd_req toggling while in RESP.
        for (int i = 0; i < 6; i++) begin
            step(mk(0,1,1,1,1,0,1,(i % 2 == 0),2'd2,0, 0,0,0,0));
            cmpv("resp_frozen", 64'(data0), 1);
            cmpv("resp_valid", 64'(valid0), 1);
        end
        step(mk(0,0,0,0,0,0,0,0,2'd0,1, 0,0,0,0));
        cmpv("resp_ack_ready", 64'(ready0), 1);
        step(mk(0,0,0,0,0,0,0,0,2'd0,1, 0,0,0,0));
        cmpv("ack_in_idle", 64'(valid0), 0);

        // Reset mid-response drops the response and zeroes everything.
        step(mk(0,1,1,1,1,0,1,0,2'd0,0, 0,0,0,0));
        step(mk(0,1,0,0,0,0,0,1,2'd3,0, 0,0,0,0));
        step(mk(1,0,0,0,0,0,0,0,2'd0,0, 0,0,0,0));
        cmpv("rst_valid", 64'(valid0), 0);
        cmpv("rst_ready", 64'(ready0), 1);
        cmpv("rst_data", 64'(data0), 0);
        step(mk(0,0,0,0,0,0,0,1,2'd3,0, 0,0,0,0));
        cmpv("rst_shadow_zero", 64'(data0), 0);
        step(mk(0,0,0,0,0,0,0,0,2'd0,1, 0,0,0,0));

        // Randomised traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            v = mk(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                   1'($urandom), 1'($urandom), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0),
                   1'($urandom), 2'($urandom), ($urandom_range(0, 2) == 0),
                   0, 0, 0, 0);
            step(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
